// File: rtl/instr_fetch_responder_if.sv
// Fetch/program-load bus between the PC-side requester and the instruction responder.
// The requester drives the master modport; the responder drives the slave modport.
interface instr_fetch_responder_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_wr_en;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic        o_ready;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic        o_fault;
  logic        o_pc_enable;

  modport master (
    output i_req, i_addr, i_flush, i_wr_en, i_wr_addr, i_wr_data,
    input  o_ready, o_instr_valid, o_instr, o_fault, o_pc_enable
  );

  modport slave (
    input  i_req, i_addr, i_flush, i_wr_en, i_wr_addr, i_wr_data,
    output o_ready, o_instr_valid, o_instr, o_fault, o_pc_enable
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction-memory responder: accepts a fetch, waits WAIT_STATES cycles, then pulses
// one instruction word and the PC enable. Misaligned/out-of-range fetches return FAULT_INSTR.
module instr_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] FAULT_INSTR = 32'h00000013
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  instr_fetch_responder_if.slave       bus
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE33   = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT    = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic        lat_fault;
  logic [31:0] instr_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] rd_addr;
  logic [32:0] rd_off;
  logic        rd_fault;
  logic [32:0] wr_off;
  logic        wr_bad;
  logic        accept;
  logic        enter_resp;

  // In IDLE the read path looks straight at the bus so a zero-wait fetch can enter RESP
  // on its acceptance edge; afterwards it uses the latched address.
  always_comb begin
    rd_addr  = (state == ST_IDLE) ? bus.i_addr : lat_addr;
    rd_off   = {1'b0, rd_addr} - BASE33;
    rd_fault = (rd_addr[1:0] != 2'b00) || ({1'b0, rd_addr} < BASE33) || (rd_off >= LIMIT);
    wr_off   = {1'b0, bus.i_wr_addr} - BASE33;
    wr_bad   = (bus.i_wr_addr[1:0] != 2'b00) || ({1'b0, bus.i_wr_addr} < BASE33) ||
               (wr_off >= LIMIT);
  end

  assign accept     = (state == ST_IDLE) && bus.i_req && !bus.i_flush;
  assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 32'd0;
      lat_fault <= 1'b0;
      instr_q   <= FAULT_INSTR;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_addr  <= bus.i_addr;
        lat_fault <= rd_fault;
        wait_cnt  <= CNT_INIT;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Non-blocking memory write below makes a same-edge write invisible here.
      if (enter_resp) begin
        instr_q <= rd_fault ? FAULT_INSTR : mem[rd_off[AW+1:2]];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_flush)            next_state = ST_IDLE;
        else if (wait_cnt == 4'd0)  next_state = ST_RESP;
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready       = (state == ST_IDLE);
    bus.o_instr_valid = (state == ST_RESP);
    bus.o_pc_enable   = (state == ST_RESP);
    bus.o_fault       = (state == ST_RESP) && lat_fault;
    bus.o_instr       = instr_q;
  end

  // Program-load port; storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_wr_en && !wr_bad) begin
      mem[wr_off[AW+1:2]] <= bus.i_wr_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: a 2-wait-state instance for most scenarios
// and a 0-wait-state instance for the single-cycle latency and reset variants.
module tb_instr_fetch_responder;

  localparam logic [31:0] W0    = 32'h00500093;
  localparam logic [31:0] W1    = 32'h00100113;
  localparam logic [31:0] W2    = 32'h00200193;
  localparam logic [31:0] W3    = 32'h00300213;
  localparam logic [31:0] FAULT = 32'h00000013;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  instr_fetch_responder_if bus();
  instr_fetch_responder_if bus0();

  instr_fetch_responder #(.WAIT_STATES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  instr_fetch_responder #(.WAIT_STATES(0)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    bus.i_wr_en  = 1'b1; bus.i_wr_addr  = addr; bus.i_wr_data  = data;
    bus0.i_wr_en = 1'b1; bus0.i_wr_addr = addr; bus0.i_wr_data = data;
    step();
    bus.i_wr_en  = 1'b0;
    bus0.i_wr_en = 1'b0;
  endtask

  // Counts cycles after acceptance until the pulse shows, bounded by budget.
  task automatic wait_valid(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      step();
      cycles++;
      if (bus.o_instr_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus.o_ready); else passes++;
    checks++; if (bus.o_instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.o_instr_valid); else passes++;
    checks++; if (bus.o_pc_enable !== 1'b0) $display("[TB] FAIL reset_pc_enable: got %b expected 0", bus.o_pc_enable); else passes++;
    checks++; if (bus.o_fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b expected 0", bus.o_fault); else passes++;
    checks++; if (bus.o_instr !== FAULT) $display("[TB] FAIL reset_instr: got %h expected %h", bus.o_instr, FAULT); else passes++;
    checks++; if (bus0.o_instr !== FAULT) $display("[TB] FAIL reset_instr_w0: got %h expected %h", bus0.o_instr, FAULT); else passes++;
  endtask

  task automatic preload();
    write_word(32'h64, W0);
    write_word(32'h68, W1);
    write_word(32'h6C, W2);
    write_word(32'h70, W3);
  endtask

  task automatic test_first_fetch();
    int cyc;
    bit seen;
    bus.i_req = 1'b1; bus.i_addr = 32'h64;
    step();
    bus.i_req = 1'b0;
    checks++; if (bus.o_ready !== 1'b0) $display("[TB] FAIL first_busy: got ready=%b expected 0", bus.o_ready); else passes++;
    wait_valid(10, cyc, seen);
    checks++; if (!seen || cyc != 2) $display("[TB] FAIL first_latency: got seen=%0d cycles=%0d expected 2", seen, cyc); else passes++;
    checks++; if (bus.o_instr !== W0) $display("[TB] FAIL first_instr: got %h expected %h", bus.o_instr, W0); else passes++;
    checks++; if (bus.o_fault !== 1'b0) $display("[TB] FAIL first_fault: got %b expected 0", bus.o_fault); else passes++;
    checks++; if (bus.o_pc_enable !== 1'b1) $display("[TB] FAIL first_pc_enable: got %b expected 1", bus.o_pc_enable); else passes++;
    step();
    checks++; if (bus.o_instr_valid !== 1'b0 || bus.o_pc_enable !== 1'b0) $display("[TB] FAIL first_pulse_width: got valid=%b pc_en=%b expected 0/0", bus.o_instr_valid, bus.o_pc_enable); else passes++;
    checks++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL first_ready_after: got %b expected 1", bus.o_ready); else passes++;
  endtask

  task automatic test_stream();
    int          pcyc [3] = '{0, 0, 0};
    logic [31:0] pins [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] exp  [3] = '{W0, W1, W2};
    int n   = 0;
    int cyc = 0;
    bus.i_addr = 32'h64; bus.i_req = 1'b1;
    while (n < 3 && cyc < 30) begin
      step();
      cyc++;
      if (bus.o_instr_valid) begin
        pcyc[n] = cyc;
        pins[n] = bus.o_instr;
        n++;
        bus.i_addr = bus.i_addr + 32'd4;
        if (n == 3) bus.i_req = 1'b0;
      end
    end
    bus.i_req = 1'b0;
    checks++; if (n != 3) $display("[TB] FAIL stream_count: got %0d pulses expected 3", n); else passes++;
    checks++; if (pcyc[0] != 3) $display("[TB] FAIL stream_first_cycle: got %0d expected 3", pcyc[0]); else passes++;
    checks++; if (pcyc[1] - pcyc[0] != 4) $display("[TB] FAIL stream_gap1: got %0d expected 4", pcyc[1] - pcyc[0]); else passes++;
    checks++; if (pcyc[2] - pcyc[1] != 4) $display("[TB] FAIL stream_gap2: got %0d expected 4", pcyc[2] - pcyc[1]); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pins[i] !== exp[i]) $display("[TB] FAIL stream_instr%0d: got %h expected %h", i, pins[i], exp[i]); else passes++;
    end
    step();
  endtask

  task automatic test_faults();
    logic [31:0] fa [4] = '{32'h66, 32'h60, 32'h464, 32'hFFFFFFFC};
    int cyc;
    bit seen;
    // Dropped writes that would alias word 0 if range or alignment checks were missing.
    write_word(32'h464, 32'hBAD0BAD0);
    write_word(32'h66,  32'hBAD1BAD1);
    for (int i = 0; i < 4; i++) begin
      bus.i_req = 1'b1; bus.i_addr = fa[i];
      step();
      bus.i_req = 1'b0;
      wait_valid(10, cyc, seen);
      checks++; if (!seen || cyc != 2) $display("[TB] FAIL fault%0d_latency: got seen=%0d cycles=%0d expected 2", i, seen, cyc); else passes++;
      checks++; if (bus.o_fault !== 1'b1) $display("[TB] FAIL fault%0d_flag: got %b expected 1", i, bus.o_fault); else passes++;
      checks++; if (bus.o_instr !== FAULT) $display("[TB] FAIL fault%0d_instr: got %h expected %h", i, bus.o_instr, FAULT); else passes++;
      step();
    end
    checks++; if (bus.o_fault !== 1'b0) $display("[TB] FAIL fault_outside_resp: got %b expected 0", bus.o_fault); else passes++;
    bus.i_req = 1'b1; bus.i_addr = 32'h64;
    step();
    bus.i_req = 1'b0;
    wait_valid(10, cyc, seen);
    checks++; if (!seen || bus.o_instr !== W0) $display("[TB] FAIL fault_mem_intact: got %h expected %h", bus.o_instr, W0); else passes++;
    checks++; if (bus.o_fault !== 1'b0) $display("[TB] FAIL fault_clear: got %b expected 0", bus.o_fault); else passes++;
    step();
  endtask

  task automatic test_flush();
    int cyc;
    bit seen;
    int stray = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h68;
    step();
    bus.i_req = 1'b0; bus.i_flush = 1'b1;
    step();
    bus.i_flush = 1'b0;
    checks++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL flush_ready: got %b expected 1", bus.o_ready); else passes++;
    checks++; if (bus.o_instr_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", bus.o_instr_valid); else passes++;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.o_instr_valid) stray++;
    end
    checks++; if (stray != 0) $display("[TB] FAIL flush_no_pulse: got %0d pulses expected 0", stray); else passes++;
    bus.i_req = 1'b1; bus.i_addr = 32'h6C;
    step();
    bus.i_req = 1'b0;
    wait_valid(10, cyc, seen);
    checks++; if (!seen || cyc != 2) $display("[TB] FAIL flush_next_latency: got seen=%0d cycles=%0d expected 2", seen, cyc); else passes++;
    checks++; if (bus.o_instr !== W2) $display("[TB] FAIL flush_next_instr: got %h expected %h", bus.o_instr, W2); else passes++;
    step();
  endtask

  task automatic test_collision();
    int cyc;
    bit seen;
    bus.i_req = 1'b1; bus.i_addr = 32'h64;
    step();
    bus.i_req = 1'b0;
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 32'h64; bus.i_wr_data = 32'hDEADBEEF;
    step();
    bus.i_wr_en = 1'b0;
    wait_valid(10, cyc, seen);
    checks++; if (!seen || cyc != 1) $display("[TB] FAIL wait_write_latency: got seen=%0d cycles=%0d expected 1", seen, cyc); else passes++;
    checks++; if (bus.o_instr !== 32'hDEADBEEF) $display("[TB] FAIL wait_write_visible: got %h expected deadbeef", bus.o_instr); else passes++;
    step();
    bus.i_req = 1'b1; bus.i_addr = 32'h64;
    step();
    bus.i_req = 1'b0;
    step();
    bus.i_wr_en = 1'b1; bus.i_wr_addr = 32'h64; bus.i_wr_data = 32'hCAFEF00D;
    step();
    bus.i_wr_en = 1'b0;
    checks++; if (bus.o_instr_valid !== 1'b1) $display("[TB] FAIL collide_valid: got %b expected 1", bus.o_instr_valid); else passes++;
    checks++; if (bus.o_instr !== 32'hDEADBEEF) $display("[TB] FAIL collide_old_value: got %h expected deadbeef", bus.o_instr); else passes++;
    step();
    bus.i_req = 1'b1; bus.i_addr = 32'h64;
    step();
    bus.i_req = 1'b0;
    wait_valid(10, cyc, seen);
    checks++; if (!seen || bus.o_instr !== 32'hCAFEF00D) $display("[TB] FAIL collide_new_value: got %h expected cafef00d", bus.o_instr); else passes++;
    step();
  endtask

  task automatic test_async_reset();
    int stray = 0;
    bus.i_req = 1'b1; bus.i_addr = 32'h68;
    step();
    bus.i_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_ready !== 1'b1) $display("[TB] FAIL areset_ready: got %b expected 1", bus.o_ready); else passes++;
    checks++; if (bus.o_instr !== FAULT) $display("[TB] FAIL areset_instr: got %h expected %h", bus.o_instr, FAULT); else passes++;
    checks++; if (bus.o_instr_valid !== 1'b0) $display("[TB] FAIL areset_valid: got %b expected 0", bus.o_instr_valid); else passes++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.o_instr_valid) stray++;
    end
    checks++; if (stray != 0) $display("[TB] FAIL areset_no_pulse: got %0d pulses expected 0", stray); else passes++;
  endtask

  task automatic test_zero_wait();
    int stray = 0;
    bus0.i_req = 1'b1; bus0.i_addr = 32'h68;
    step();
    bus0.i_req = 1'b0;
    checks++; if (bus0.o_instr_valid !== 1'b1) $display("[TB] FAIL zw_latency: got valid=%b expected 1", bus0.o_instr_valid); else passes++;
    checks++; if (bus0.o_instr !== W1) $display("[TB] FAIL zw_instr: got %h expected %h", bus0.o_instr, W1); else passes++;
    checks++; if (bus0.o_pc_enable !== 1'b1) $display("[TB] FAIL zw_pc_enable: got %b expected 1", bus0.o_pc_enable); else passes++;
    step();
    bus0.i_req = 1'b1; bus0.i_addr = 32'h6C;
    step();
    bus0.i_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus0.o_instr_valid !== 1'b0 || bus0.o_pc_enable !== 1'b0) $display("[TB] FAIL zw_areset_valid: got valid=%b pc_en=%b expected 0/0", bus0.o_instr_valid, bus0.o_pc_enable); else passes++;
    checks++; if (bus0.o_instr !== FAULT) $display("[TB] FAIL zw_areset_instr: got %h expected %h", bus0.o_instr, FAULT); else passes++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus0.o_instr_valid) stray++;
    end
    checks++; if (stray != 0) $display("[TB] FAIL zw_no_pulse: got %0d pulses expected 0", stray); else passes++;
    bus0.i_req = 1'b1; bus0.i_addr = 32'h70;
    step();
    bus0.i_req = 1'b0;
    checks++; if (bus0.o_instr_valid !== 1'b1 || bus0.o_instr !== W3) $display("[TB] FAIL zw_after_reset: got valid=%b instr=%h expected 1/%h", bus0.o_instr_valid, bus0.o_instr, W3); else passes++;
    step();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    bus.i_req  = 1'b0; bus.i_addr  = 32'h0; bus.i_flush  = 1'b0;
    bus.i_wr_en  = 1'b0; bus.i_wr_addr  = 32'h0; bus.i_wr_data  = 32'h0;
    bus0.i_req = 1'b0; bus0.i_addr = 32'h0; bus0.i_flush = 1'b0;
    bus0.i_wr_en = 1'b0; bus0.i_wr_addr = 32'h0; bus0.i_wr_data = 32'h0;
    #2 rst_n = 1'b0;
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    preload();
    test_first_fetch();
    test_stream();
    test_faults();
    test_flush();
    test_collision();
    test_async_reset();
    test_zero_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-memory responder that serves fetch requests from the program counter in the single-cycle data path. It accepts a 32-bit byte address, waits a configurable number of cycles, then returns one instruction word with a single-cycle valid pulse. It drives the PC clock-enable so the PC advances exactly once per delivered instruction. It also provides a program-load write port, and flags misaligned or out-of-range fetches.

## Interface
- DEPTH_WORDS, 256: instruction storage size in 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h64: byte address of word 0; word aligned.
- WAIT_STATES, 2: extra cycles between request acceptance and response; range 0–15.
- FAULT_INSTR, 32'h00000013: word returned on a fault (RV32I NOP).
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; sampled only while o_ready=1.
- i_addr  in  32  fetch byte address; sampled with i_req.
- i_flush  in  1  abort any in-flight fetch.
- i_wr_en  in  1  program-load write strobe.
- i_wr_addr  in  32  program-load byte address; same mapping as fetches.
- i_wr_data  in  32  program-load data.
- o_ready  out  1  responder idle and able to accept a request.
- o_instr_valid  out  1  one-cycle pulse: o_instr and o_fault are valid.
- o_instr  out  32  fetched instruction word.
- o_fault  out  1  fetch was misaligned or out of range; qualified by o_instr_valid.
- o_pc_enable  out  1  connects to the PC clock-enable; equals o_instr_valid.

## Operation
- States: IDLE, WAIT, RESP. o_ready=1 only in IDLE.
- IDLE & i_req:
  - latch i_addr;
  - compute fault = (i_addr[1:0]≠0) | (i_addr < BASE_ADDR) | (i_addr − BASE_ADDR ≥ 4·DEPTH_WORDS), using 33-bit unsigned comparison so no wrap-around aliasing occurs;
  - go to RESP if WAIT_STATES=0, else go to WAIT with counter = WAIT_STATES−1.
- IDLE & !i_req: stay in IDLE. i_addr is ignored.
- WAIT: counter decrements each cycle; go to RESP when counter=0.
- Entering RESP: o_instr is registered from memory word (latched_addr − BASE_ADDR)>>2. If fault, o_instr = FAULT_INSTR and the memory is not read.
- RESP: o_instr_valid=1, o_pc_enable=1, o_fault=latched fault. Next state is always IDLE.
- o_instr holds its last value outside RESP. o_fault reads 0 outside RESP.
- i_flush, any state: next state is IDLE, and no o_instr_valid is produced for the aborted fetch. If i_flush and RESP coincide, the current pulse still completes, since it was already registered. i_flush has priority over i_req in IDLE.
- Write port:
  - when i_wr_en is high and the address is aligned and in range, the word is written on the edge;
  - invalid write addresses are silently dropped;
  - writes are allowed in every state.
- Write/read collision: a write on the same edge that enters RESP to the same word is not visible (read-before-write). A write during WAIT is visible.
- Memory contents are not reset. Fetches from unwritten words return X in simulation; benches must preload.

## Timing
- Reset (asynchronous, immediate) drives: state=IDLE, o_ready=1, o_instr_valid=0, o_pc_enable=0, o_fault=0, o_instr=FAULT_INSTR, counter=0.
- Reset release is synchronous to the next edge. The first request can be accepted on the first edge after deassertion.
- Latency: request sampled at edge E0 → o_instr_valid high in the cycle after edge E0+WAIT_STATES, i.e. WAIT_STATES+1 cycles after acceptance.
- Throughput: one instruction per WAIT_STATES+2 cycles with i_req held high.
- The PC loads its next value on the edge ending the RESP cycle. The new address is therefore stable when IDLE samples it on the following edge.
- Reset asserted mid-fetch: the fetch is discarded, and no valid pulse occurs after release.

## Test plan
- Reset and first fetch: preload word 0 = 32'h00500093. Release reset, then i_req=1, i_addr=32'h64, WAIT_STATES=2. Required: o_instr_valid high exactly 3 cycles after acceptance, o_instr=32'h00500093, o_fault=0, o_pc_enable high for exactly 1 cycle.
- Sequential stream: addresses 0x64, 0x68, 0x6C with i_req held high. Required: three valid pulses spaced 4 cycles apart, carrying preloaded words 0, 1, 2.
- Faults, DEPTH_WORDS=256: fetches at 0x66, 0x60, 0x464 and 0xFFFFFFFC. Required: each returns o_fault=1 and o_instr=32'h00000013 with normal latency; memory is unchanged.
- Flush: i_flush=1 one cycle after accepting 0x68. Required: no o_instr_valid, o_ready=1 on the next cycle, and the next request completes normally.
- Write collision: write 32'hDEADBEEF to 0x64 during WAIT → returned. Write 32'hCAFEF00D on the RESP-entry edge → old value returned, new value returned on the next fetch.
- Asynchronous reset in WAIT, with WAIT_STATES=0 variant also run: outputs go to reset values immediately without a clock edge. No valid pulse after release; the 1-cycle latency holds for the 0-wait variant.
